// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
// Shared constants for the execute stage: the ALU control code width and the
// six supported ALU control codes produced by the ALU-control decoder.
// No ports (package).
// ---------------------------------------------------------------------------
package alu_pkg;

  localparam int ALU_CTR_W = 4;

  localparam logic [ALU_CTR_W-1:0] ALU_AND = 4'b0000;
  localparam logic [ALU_CTR_W-1:0] ALU_OR  = 4'b0001;
  localparam logic [ALU_CTR_W-1:0] ALU_ADD = 4'b0010;
  localparam logic [ALU_CTR_W-1:0] ALU_SUB = 4'b0110;
  localparam logic [ALU_CTR_W-1:0] ALU_SLT = 4'b0111;
  localparam logic [ALU_CTR_W-1:0] ALU_NOR = 4'b1100;

endpackage : alu_pkg

// File: rtl/alu_ex_stage_if.sv
// ---------------------------------------------------------------------------
// alu_ex_stage_if
// Bundles the upstream (decoder -> EX) and downstream (EX -> MEM) handshake
// and data signals of the execute stage.
//
// Handshake (both sides): a transfer happens on a rising edge where valid and
// ready are both 1. The producer holds valid and its data stable until that
// edge; ready may depend combinationally on the consumer's state. flush is a
// side-band kill of the op held in the stage and of any op offered with it.
//
// Signals:
//   inValid/inReady        upstream handshake
//   aluCtr, srcA, srcB     ALU control code and operands
//   inTag                  destination register tag
//   flush                  kill held op (branch/exception)
//   outValid/outReady      downstream handshake
//   aluResult, aluZero     registered result and (result == 0)
//   outTag, aluIllegal     registered tag and unsupported-code flag
//   aluOvf                 registered ADD/SUB signed overflow
//                          (present only with ALU_OVERFLOW_EN)
// Modports: master = decoder/memory side driving the stage, slave = stage.
// ---------------------------------------------------------------------------
interface alu_ex_stage_if
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int TAG_W = 5
);

  logic                 inValid;
  logic                 inReady;
  logic [ALU_CTR_W-1:0] aluCtr;
  logic [WIDTH-1:0]     srcA;
  logic [WIDTH-1:0]     srcB;
  logic [TAG_W-1:0]     inTag;
  logic                 flush;
  logic                 outValid;
  logic                 outReady;
  logic [WIDTH-1:0]     aluResult;
  logic                 aluZero;
  logic [TAG_W-1:0]     outTag;
  logic                 aluIllegal;
`ifdef ALU_OVERFLOW_EN
  logic                 aluOvf;
`endif

  modport master (
    output inValid, aluCtr, srcA, srcB, inTag, flush, outReady,
    input  inReady, outValid, aluResult, aluZero, outTag, aluIllegal
`ifdef ALU_OVERFLOW_EN
    , input aluOvf
`endif
  );

  modport slave (
    input  inValid, aluCtr, srcA, srcB, inTag, flush, outReady,
    output inReady, outValid, aluResult, aluZero, outTag, aluIllegal
`ifdef ALU_OVERFLOW_EN
    , output aluOvf
`endif
  );

endinterface : alu_ex_stage_if

// File: rtl/alu_core.sv
// ---------------------------------------------------------------------------
// alu_core
// Purely combinational ALU.
//   alu_ctr_i  in   ALU control code
//   src_a_i    in   operand A
//   src_b_i    in   operand B
//   result_o   out  result (0 for unsupported codes)
//   illegal_o  out  1 when the code is not one of the six supported codes
//   ovf_o      out  signed overflow of ADD/SUB, 0 for every other code
// ---------------------------------------------------------------------------
module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [ALU_CTR_W-1:0] alu_ctr_i,
  input  logic [WIDTH-1:0]     src_a_i,
  input  logic [WIDTH-1:0]     src_b_i,
  output logic [WIDTH-1:0]     result_o,
  output logic                 illegal_o,
  output logic                 ovf_o
);

  localparam int MSB = WIDTH - 1;

  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] diff;
  logic             add_ovf;
  logic             sub_ovf;
  logic             slt;

  assign sum  = src_a_i + src_b_i;
  // Subtraction as A + ~B + 1 so the subtractor is the adder with inverted B.
  assign diff = src_a_i + ~src_b_i + {{(WIDTH-1){1'b0}}, 1'b1};

  // Overflow: operands agree in sign (ADD) / differ in sign (SUB) and the
  // result sign differs from A.
  assign add_ovf = (src_a_i[MSB] == src_b_i[MSB]) && (sum[MSB]  != src_a_i[MSB]);
  assign sub_ovf = (src_a_i[MSB] != src_b_i[MSB]) && (diff[MSB] != src_a_i[MSB]);

  // True signed less-than: the sign of the difference is wrong exactly when
  // the subtraction overflowed.
  assign slt = diff[MSB] ^ sub_ovf;

  always_comb begin
    result_o  = '0;
    illegal_o = 1'b0;
    ovf_o     = 1'b0;
    unique case (alu_ctr_i)
      ALU_ADD: begin
        result_o = sum;
        ovf_o    = add_ovf;
      end
      ALU_SUB: begin
        result_o = diff;
        ovf_o    = sub_ovf;
      end
      ALU_AND: result_o = src_a_i & src_b_i;
      ALU_OR:  result_o = src_a_i | src_b_i;
      ALU_SLT: result_o = {{(WIDTH-1){1'b0}}, slt};
      ALU_NOR: result_o = ~(src_a_i | src_b_i);
      default: illegal_o = 1'b1;
    endcase
  end

endmodule : alu_core

// File: rtl/alu_ex_stage.sv
// ---------------------------------------------------------------------------
// alu_ex_stage
// Execute stage: computes the ALU result for the op offered upstream and
// holds it, with zero flag and destination tag, in the EX/MEM register.
//   clk      in   rising-edge clock
//   reset_n  in   synchronous active-low reset
//   ex       slave modport of alu_ex_stage_if (handshakes, operands, results)
//
// Optional feature, macro ALU_OVERFLOW_EN: adds the registered aluOvf flag;
// an overflowing ADD/SUB has its outTag forced to 0 so write-back is
// suppressed. Without the macro overflow is ignored and outTag = inTag.
//
// Single-entry stage, no skid buffer: inReady = !outValid || outReady, so a
// drain and a load can share one edge and the stage runs at full throughput.
// flush wins over stall and load; reset wins over flush.
// ---------------------------------------------------------------------------
module alu_ex_stage #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 5
) (
  input logic           clk,
  input logic           reset_n,
  alu_ex_stage_if.slave ex
);

  logic [WIDTH-1:0] core_result;
  logic             core_illegal;
  logic             core_ovf;

  alu_core #(.WIDTH(WIDTH)) u_alu_core (
    .alu_ctr_i (ex.aluCtr),
    .src_a_i   (ex.srcA),
    .src_b_i   (ex.srcB),
    .result_o  (core_result),
    .illegal_o (core_illegal),
    .ovf_o     (core_ovf)
  );

  logic             valid_q,   valid_d;
  logic [WIDTH-1:0] result_q,  result_d;
  logic             zero_q,    zero_d;
  logic [TAG_W-1:0] tag_q,     tag_d;
  logic             illegal_q, illegal_d;
`ifdef ALU_OVERFLOW_EN
  logic             ovf_q,     ovf_d;
`else
  logic             unused_ovf;
  assign unused_ovf = core_ovf;
`endif

  logic in_ready;
  logic load;

  assign in_ready = !valid_q || ex.outReady;
  assign load     = ex.inValid && in_ready && !ex.flush;

  always_comb begin
    valid_d   = valid_q;
    result_d  = result_q;
    zero_d    = zero_q;
    tag_d     = tag_q;
    illegal_d = illegal_q;
`ifdef ALU_OVERFLOW_EN
    ovf_d     = ovf_q;
`endif
    if (ex.flush) begin
      valid_d = 1'b0;
    end else if (load) begin
      valid_d = 1'b1;
    end else if (valid_q && ex.outReady) begin
      valid_d = 1'b0;
    end

    // Data registers change only on a load; a flushed load leaves them stale.
    if (load) begin
      result_d  = core_result;
      zero_d    = (core_result == '0);
      illegal_d = core_illegal;
`ifdef ALU_OVERFLOW_EN
      ovf_d     = core_ovf;
      tag_d     = core_ovf ? '0 : ex.inTag;
`else
      tag_d     = ex.inTag;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      valid_q   <= 1'b0;
      result_q  <= '0;
      zero_q    <= 1'b1;
      tag_q     <= '0;
      illegal_q <= 1'b0;
`ifdef ALU_OVERFLOW_EN
      ovf_q     <= 1'b0;
`endif
    end else begin
      valid_q   <= valid_d;
      result_q  <= result_d;
      zero_q    <= zero_d;
      tag_q     <= tag_d;
      illegal_q <= illegal_d;
`ifdef ALU_OVERFLOW_EN
      ovf_q     <= ovf_d;
`endif
    end
  end

  assign ex.inReady    = in_ready;
  assign ex.outValid   = valid_q;
  assign ex.aluResult  = result_q;
  assign ex.aluZero    = zero_q;
  assign ex.outTag     = tag_q;
  assign ex.aluIllegal = illegal_q;
`ifdef ALU_OVERFLOW_EN
  assign ex.aluOvf     = ovf_q;
`endif

endmodule : alu_ex_stage

// File: tb/tb_alu_ex_stage.sv
// ---------------------------------------------------------------------------
// tb_alu_ex_stage
// Self-checking bench for alu_ex_stage (WIDTH=32, TAG_W=5). Inputs change #1
// after the rising edge; outputs are checked on the falling edge. The
// scoreboard queue holds the op expected in the EX/MEM register.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_alu_ex_stage;

  localparam int WIDTH = 32;
  localparam int TAG_W = 5;
  localparam int OUT_W = 1 + 1 + TAG_W + 1 + WIDTH;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  alu_ex_stage_if #(.WIDTH(WIDTH), .TAG_W(TAG_W)) bus ();

  alu_ex_stage #(.WIDTH(WIDTH), .TAG_W(TAG_W)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .ex      (bus)
  );

  // ---------------- scoreboard ----------------
  logic [OUT_W-1:0] exp_q[$];
  int tests_run = 0;
  int tests_failed = 0;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Reference model, written from the behavioural description.
  function automatic logic [OUT_W-1:0] model(input logic [3:0] ctr, input logic [WIDTH-1:0] a,
                                             input logic [WIDTH-1:0] b, input logic [TAG_W-1:0] tag);
    logic [WIDTH-1:0] r;
    logic             ill;
    logic             ovf;
    longint           s;
    r = '0; ill = 1'b0; ovf = 1'b0; s = 0;
    case (ctr)
      4'b0010: begin
        r = a + b;
        s = longint'($signed(a)) + longint'($signed(b));
        ovf = (s != longint'($signed(r)));
      end
      4'b0110: begin
        r = a - b;
        s = longint'($signed(a)) - longint'($signed(b));
        ovf = (s != longint'($signed(r)));
      end
      4'b0000: r = a & b;
      4'b0001: r = a | b;
      4'b0111: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'b1100: r = ~(a | b);
      default: ill = 1'b1;
    endcase
`ifdef ALU_OVERFLOW_EN
    if (ovf) tag = '0;
`else
    ovf = 1'b0;
`endif
    return {ill, ovf, tag, (r == '0), r};
  endfunction

  function automatic logic [OUT_W-1:0] observed();
    logic ovf_obs;
`ifdef ALU_OVERFLOW_EN
    ovf_obs = bus.aluOvf;
`else
    ovf_obs = 1'b0;
`endif
    return {bus.aluIllegal, ovf_obs, bus.outTag, bus.aluZero, bus.aluResult};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive(input logic v, input logic [3:0] ctr, input logic [WIDTH-1:0] a,
                       input logic [WIDTH-1:0] b, input logic [TAG_W-1:0] tag);
    bus.inValid = v;
    bus.aluCtr  = ctr;
    bus.srcA    = a;
    bus.srcB    = b;
    bus.inTag   = tag;
  endtask

  // One clock: check current outputs against the scoreboard, update the
  // scoreboard with what the coming edge does, then step past the edge.
  task automatic cycle();
    logic rdy_m;
    @(negedge clk);
    rdy_m = (exp_q.size() == 0) || bus.outReady;
    check_eq("in_ready", bus.inReady, rdy_m);
    check_eq("out_valid", bus.outValid, exp_q.size() != 0);
    if (exp_q.size() != 0) check_eq("out_data", observed(), exp_q[0]);
    if (!reset_n) begin
      exp_q.delete();
    end else if (bus.flush) begin
      if (exp_q.size() != 0) void'(exp_q.pop_front());
    end else begin
      if (exp_q.size() != 0 && bus.outReady) void'(exp_q.pop_front());
      if (bus.inValid && rdy_m) exp_q.push_back(model(bus.aluCtr, bus.srcA, bus.srcB, bus.inTag));
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  logic [3:0] codes [7] = '{4'b0010, 4'b0110, 4'b0000, 4'b0001, 4'b0111, 4'b1100, 4'b1010};

  initial begin
    bus.flush    = 1'b0;
    bus.outReady = 1'b0;
    drive(1'b0, 4'b0, '0, '0, '0);

    // 1. reset then idle
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    @(negedge clk);
    check_eq("rst_valid", bus.outValid, 1'b0);
    check_eq("rst_zero", bus.aluZero, 1'b1);
    check_eq("rst_result", bus.aluResult, 32'h0);
    check_eq("rst_tag", bus.outTag, 5'd0);
    check_eq("rst_illegal", bus.aluIllegal, 1'b0);
    check_eq("rst_ready", bus.inReady, 1'b1);
    @(posedge clk); #1;

    // 2. ADD overflow case
    bus.outReady = 1'b1;
    drive(1'b1, 4'b0010, 32'h7FFF_FFFF, 32'h1, 5'd3);
    cycle();
    drive(1'b0, 4'b0, '0, '0, '0);
    check_eq("add_result", bus.aluResult, 32'h8000_0000);
    check_eq("add_valid", bus.outValid, 1'b1);
`ifdef ALU_OVERFLOW_EN
    check_eq("add_ovf", bus.aluOvf, 1'b1);
    check_eq("add_tag", bus.outTag, 5'd0);
`else
    check_eq("add_tag", bus.outTag, 5'd3);
`endif
    cycle();

    // 3. SLT then SUB back to back
    drive(1'b1, 4'b0111, 32'h8000_0000, 32'h1, 5'd4);
    cycle();
    check_eq("slt_result", bus.aluResult, 32'h1);
    drive(1'b1, 4'b0110, 32'd5, 32'd5, 5'd5);
    cycle();
    check_eq("sub_result", bus.aluResult, 32'h0);
    check_eq("sub_zero", bus.aluZero, 1'b1);
    drive(1'b0, 4'b0, '0, '0, '0);
    cycle();

    // 4. stall with a second op waiting
    bus.outReady = 1'b0;
    drive(1'b1, 4'b0000, 32'hF0F0_1234, 32'h0FF0_FFFF, 5'd6);
    cycle();
    drive(1'b1, 4'b0001, 32'h0000_00F0, 32'h0000_000F, 5'd7);
    repeat (3) begin
      cycle();
      check_eq("stall_ready", bus.inReady, 1'b0);
      check_eq("stall_hold", bus.aluResult, 32'h00F0_1234);
    end
    bus.outReady = 1'b1;
    cycle();
    check_eq("stall_second", bus.aluResult, 32'h0000_00FF);
    check_eq("stall_second_tag", bus.outTag, 5'd7);
    drive(1'b0, 4'b0, '0, '0, '0);
    cycle();

    // 5. flush while holding, with a concurrent offer
    bus.outReady = 1'b0;
    drive(1'b1, 4'b1100, 32'h0, 32'h0, 5'd8);
    cycle();
    drive(1'b1, 4'b0010, 32'd1, 32'd2, 5'd9);
    bus.flush = 1'b1;
    cycle();
    bus.flush = 1'b0;
    drive(1'b0, 4'b0, '0, '0, '0);
    check_eq("flush_valid", bus.outValid, 1'b0);
    cycle();
    check_eq("flush_no_load", bus.outValid, 1'b0);

    // 6. illegal code
    bus.outReady = 1'b1;
    drive(1'b1, 4'b1111, 32'h0000_FFFF, 32'h1, 5'd10);
    cycle();
    drive(1'b0, 4'b0, '0, '0, '0);
    check_eq("ill_flag", bus.aluIllegal, 1'b1);
    check_eq("ill_result", bus.aluResult, 32'h0);
    check_eq("ill_valid", bus.outValid, 1'b1);
    cycle();

    // 7. random traffic
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 1) == 1, codes[$urandom_range(0, 6)],
            ($urandom_range(0, 3) == 0) ? 32'h7FFF_FFFF : $urandom,
            ($urandom_range(0, 3) == 0) ? 32'h8000_0000 : $urandom,
            5'($urandom_range(0, 31)));
      bus.outReady = $urandom_range(0, 2) != 0;
      bus.flush    = $urandom_range(0, 9) == 0;
      cycle();
    end
    bus.flush = 1'b0;
    drive(1'b0, 4'b0, '0, '0, '0);
    bus.outReady = 1'b1;
    cycle();

    // 8. reset during a stall drops the held op
    bus.outReady = 1'b0;
    drive(1'b1, 4'b0001, 32'h1234_0000, 32'h0000_5678, 5'd11);
    cycle();
    drive(1'b0, 4'b0, '0, '0, '0);
    reset_n = 1'b0;
    cycle();
    reset_n = 1'b1;
    check_eq("rst_stall_valid", bus.outValid, 1'b0);
    check_eq("rst_stall_result", bus.aluResult, 32'h0);
    check_eq("rst_stall_zero", bus.aluZero, 1'b1);
    check_eq("rst_stall_tag", bus.outTag, 5'd0);
    cycle();
    check_eq("rst_stall_idle", bus.outValid, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule : tb_alu_ex_stage
